// File: rtl/mem_pkg.sv
// Shared types, opcodes and decode helpers for the MEM pipeline stage.
// Also provides default datapath width macros when the build does not supply them.
`ifndef W_OPER
`define W_OPER 6
`endif
`ifndef W_REGF
`define W_REGF 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_ADDR
`define W_ADDR 32
`endif

package mem_pkg;

    // Operation codes: memory ops reuse the MIPS primary opcodes.
    localparam logic [`W_OPER-1:0] OP_NOP = 6'h00;
    localparam logic [`W_OPER-1:0] OP_ADD = 6'h01;
    localparam logic [`W_OPER-1:0] OP_SUB = 6'h02;
    localparam logic [`W_OPER-1:0] OP_LB  = 6'h20;
    localparam logic [`W_OPER-1:0] OP_LH  = 6'h21;
    localparam logic [`W_OPER-1:0] OP_LW  = 6'h23;
    localparam logic [`W_OPER-1:0] OP_LBU = 6'h24;
    localparam logic [`W_OPER-1:0] OP_LHU = 6'h25;
    localparam logic [`W_OPER-1:0] OP_SB  = 6'h28;
    localparam logic [`W_OPER-1:0] OP_SH  = 6'h29;
    localparam logic [`W_OPER-1:0] OP_SW  = 6'h2B;

    typedef enum logic [3:0] {
        NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
    } mm_kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mem_state_t;

    function automatic mm_kind_t decode_mm(input logic [`W_OPER-1:0] oper);
        mm_kind_t kind;
        case (oper)
            OP_LB:   kind = LB;
            OP_LBU:  kind = LBU;
            OP_LH:   kind = LH;
            OP_LHU:  kind = LHU;
            OP_LW:   kind = LW;
            OP_SB:   kind = SB;
            OP_SH:   kind = SH;
            OP_SW:   kind = SW;
            default: kind = NONE;
        endcase
        return kind;
    endfunction

    function automatic logic is_load(input mm_kind_t kind);
        return (kind == LB) || (kind == LBU) || (kind == LH) ||
               (kind == LHU) || (kind == LW);
    endfunction

    function automatic logic is_store(input mm_kind_t kind);
        return (kind == SB) || (kind == SH) || (kind == SW);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data bus between the MEM stage (master) and the data memory (slave):
// one registered request, acknowledged with same-cycle read data.
interface mem_access_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, wr, addr, wstrb, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, wr, addr, wstrb, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/load_ext.sv
// Little-endian lane select and sign/zero extension of a read word.
module load_ext
    import mem_pkg::*;
(
    input  mm_kind_t    kind,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = 32'd0;
        case (kind)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            LW:      data = rdata;
            default: data = 32'd0;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// MEM stage of the MIPS pipeline: single-outstanding data bus transaction with stall,
// load alignment/extension and MEM/WB register. Option: MEM_ALIGN_CHECK_EN.
module mem_access
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [`W_OPER-1:0]  oper,
    input  logic [`W_ADDR-1:0]  addr,
    input  logic [`W_DATA-1:0]  wr_data,
    input  logic [`W_DATA-1:0]  rd_data_a,
    input  logic [`W_ADDR-1:0]  pc,
    input  logic [`W_REGF-1:0]  rd_regf,
    output logic                stall,
    mem_access_if.master        bus,
    output logic                valid_out,
    output logic [`W_OPER-1:0]  oper_out,
    output logic [`W_REGF-1:0]  rd_regf_out,
    output logic [`W_DATA-1:0]  rd_data_a_out,
    output logic [`W_DATA-1:0]  rd_data_b,
    output logic [`W_ADDR-1:0]  pc_out,
    output logic                exc_misalign,
    output logic [31:0]         badvaddr
);
    mm_kind_t    kind;
    mem_state_t  state, state_nx;
    logic        ld, st, is_mem, misalign, start;
    logic [3:0]  wstrb_nx;
    logic [31:0] wdata_nx;
    logic [31:0] ld_data;

    assign kind   = decode_mm(oper);
    assign ld     = is_load(kind);
    assign st     = is_store(kind);
    assign is_mem = ld || st;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (kind)
            LH, LHU, SH: misalign = addr[0];
            LW, SW:      misalign = |addr[1:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_in && is_mem && !misalign) begin
                    start    = 1'b1;
                    stall    = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = !bus.ack;
                if (bus.ack)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Sub-word stores replicate the data across lanes; the strobe picks the live one.
    always_comb begin
        wstrb_nx = 4'b0000;
        wdata_nx = 32'd0;
        case (kind)
            SB: begin
                wstrb_nx = 4'b0001 << addr[1:0];
                wdata_nx = {4{wr_data[7:0]}};
            end
            SH: begin
                wstrb_nx = addr[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{wr_data[15:0]}};
            end
            SW: begin
                wstrb_nx = 4'b1111;
                wdata_nx = wr_data;
            end
            default: begin
                wstrb_nx = 4'b0000;
                wdata_nx = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.req   <= 1'b0;
            bus.wr    <= 1'b0;
            bus.addr  <= 32'd0;
            bus.wstrb <= 4'b0000;
            bus.wdata <= 32'd0;
        end else if (start) begin
            bus.req   <= 1'b1;
            bus.wr    <= st;
            bus.addr  <= {addr[31:2], 2'b00};
            bus.wstrb <= wstrb_nx;
            bus.wdata <= wdata_nx;
        end else if (state == ST_BUSY && bus.ack) begin
            bus.req   <= 1'b0;
        end
    end

    load_ext u_load_ext (
        .kind  (kind),
        .lane  (addr[1:0]),
        .rdata (bus.rdata),
        .data  (ld_data)
    );

    // A stalled cycle emits a bubble; a misaligned op still retires, with its write suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            oper_out      <= '0;
            rd_regf_out   <= '0;
            rd_data_a_out <= '0;
            rd_data_b     <= '0;
            pc_out        <= '0;
            exc_misalign  <= 1'b0;
            badvaddr      <= 32'd0;
        end else if (!stall) begin
            valid_out     <= valid_in;
            oper_out      <= oper;
            rd_regf_out   <= (valid_in && misalign) ? '0 : rd_regf;
            rd_data_a_out <= rd_data_a;
            rd_data_b     <= (state == ST_BUSY && bus.ack && ld) ? ld_data : 32'd0;
            pc_out        <= pc;
            exc_misalign  <= valid_in && misalign;
            badvaddr      <= (valid_in && misalign) ? addr : 32'd0;
        end else begin
            valid_out     <= 1'b0;
            exc_misalign  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (honours MEM_ALIGN_CHECK_EN when defined).
`ifndef W_OPER
`define W_OPER 6
`endif
`ifndef W_REGF
`define W_REGF 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_ADDR
`define W_ADDR 32
`endif

module tb_mem_access;
    import mem_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic [`W_OPER-1:0]  oper;
    logic [`W_ADDR-1:0]  addr;
    logic [`W_DATA-1:0]  wr_data;
    logic [`W_DATA-1:0]  rd_data_a;
    logic [`W_ADDR-1:0]  pc;
    logic [`W_REGF-1:0]  rd_regf;
    logic                stall;
    logic                valid_out;
    logic [`W_OPER-1:0]  oper_out;
    logic [`W_REGF-1:0]  rd_regf_out;
    logic [`W_DATA-1:0]  rd_data_a_out;
    logic [`W_DATA-1:0]  rd_data_b;
    logic [`W_ADDR-1:0]  pc_out;
    logic                exc_misalign;
    logic [31:0]         badvaddr;

    int total = 0;
    int bad = 0;
    int req_starts = 0;
    logic req_prev = 1'b0;

    mem_access_if bus ();

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .oper          (oper),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data_a     (rd_data_a),
        .pc            (pc),
        .rd_regf       (rd_regf),
        .stall         (stall),
        .bus           (bus),
        .valid_out     (valid_out),
        .oper_out      (oper_out),
        .rd_regf_out   (rd_regf_out),
        .rd_data_a_out (rd_data_a_out),
        .rd_data_b     (rd_data_b),
        .pc_out        (pc_out),
        .exc_misalign  (exc_misalign),
        .badvaddr      (badvaddr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.req && !req_prev)
            req_starts++;
        req_prev = bus.req;
    end

    task automatic drive(input logic [`W_OPER-1:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rda,
                         input logic [4:0] rd);
        valid_in  = 1'b1;
        oper      = op;
        addr      = a;
        wr_data   = wd;
        rd_data_a = rda;
        rd_regf   = rd;
        pc        = 32'h0000_0400;
    endtask

    // Runs one memop from IDLE, acking after wait_n BUSY cycles; entered just after an edge.
    task automatic run_memop(input logic [`W_OPER-1:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input int wait_n, input logic [31:0] rdata,
                             output int stall_cnt, output logic s_req, output logic s_wr,
                             output logic [31:0] s_addr, output logic [3:0] s_strb,
                             output logic [31:0] s_wdata, output logic r_valid,
                             output logic [31:0] r_data_b, output logic r_req);
        drive(op, a, wd, 32'h1111_2222, 5'd5);
        #1;
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        s_req = bus.req; s_wr = bus.wr; s_addr = bus.addr;
        s_strb = bus.wstrb; s_wdata = bus.wdata;
        for (int i = 0; i < wait_n; i++) begin
            if (stall) stall_cnt++;
            @(posedge clk); #1;
        end
        bus.ack = 1'b1;
        bus.rdata = rdata;
        #1;
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        valid_in = 1'b0;
        r_valid = valid_out; r_data_b = rd_data_b; r_req = bus.req;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b0; oper = OP_NOP; addr = '0; wr_data = '0;
        rd_data_a = '0; pc = '0; rd_regf = '0;
        bus.ack = 1'b0; bus.rdata = '0;
        @(posedge clk); #1;
        total++;
        if ({valid_out, oper_out, rd_regf_out, rd_data_a_out, rd_data_b, pc_out,
             exc_misalign, badvaddr, bus.req, bus.wr, bus.addr, bus.wstrb, bus.wdata} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got valid=%b req=%b data_b=%h want all zero",
                     valid_out, bus.req, rd_data_b);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_stall got=%b want=0", stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw_wait();
        int sc; logic sreq, swr, rv, rreq; logic [31:0] sa, swd, rdb; logic [3:0] ss;
        run_memop(OP_LW, 32'h1000, 32'h0, 3, 32'hDEAD_BEEF, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (sc !== 4) begin bad++; $display("[TB] FAIL lw_stall_cycles got=%0d want=4", sc); end
        total++; if (sreq !== 1'b1) begin bad++; $display("[TB] FAIL lw_req got=%b want=1", sreq); end
        total++; if (sa !== 32'h1000) begin bad++; $display("[TB] FAIL lw_addr got=%h want=00001000", sa); end
        total++; if ({swr, ss} !== 5'b0) begin bad++; $display("[TB] FAIL lw_wr_strb got=%b%b want=0 0000", swr, ss); end
        total++; if (rv !== 1'b1) begin bad++; $display("[TB] FAIL lw_valid got=%b want=1", rv); end
        total++; if (rdb !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lw_data got=%h want=deadbeef", rdb); end
        total++; if (rreq !== 1'b0) begin bad++; $display("[TB] FAIL lw_req_drop got=%b want=0", rreq); end
        total++; if (rd_regf_out !== 5'd5) begin bad++; $display("[TB] FAIL lw_rd_regf got=%0d want=5", rd_regf_out); end
    endtask

    task automatic test_load_ext();
        int sc; logic sreq, swr, rv, rreq; logic [31:0] sa, swd, rdb; logic [3:0] ss;
        run_memop(OP_LB, 32'h1003, 32'h0, 0, 32'h80FF_0000, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (rdb !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_data got=%h want=ffffff80", rdb); end
        total++; if (sc !== 1) begin bad++; $display("[TB] FAIL lb_stall_cycles got=%0d want=1", sc); end
        run_memop(OP_LBU, 32'h1003, 32'h0, 1, 32'h80FF_0000, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (rdb !== 32'h0000_0080) begin bad++; $display("[TB] FAIL lbu_data got=%h want=00000080", rdb); end
        run_memop(OP_LH, 32'h1002, 32'h0, 0, 32'h80FF_0000, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (rdb !== 32'hFFFF_80FF) begin bad++; $display("[TB] FAIL lh_data got=%h want=ffff80ff", rdb); end
        run_memop(OP_LHU, 32'h1000, 32'h0, 0, 32'h1234_F00D, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (rdb !== 32'h0000_F00D) begin bad++; $display("[TB] FAIL lhu_data got=%h want=0000f00d", rdb); end
        run_memop(OP_LB, 32'h1001, 32'h0, 0, 32'h0000_7F00, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (rdb !== 32'h0000_007F) begin bad++; $display("[TB] FAIL lb_pos_data got=%h want=0000007f", rdb); end
    endtask

    task automatic test_store();
        int sc; logic sreq, swr, rv, rreq; logic [31:0] sa, swd, rdb; logic [3:0] ss;
        run_memop(OP_SH, 32'h2002, 32'h0000_ABCD, 0, 32'h5555_5555, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (ss !== 4'b1100) begin bad++; $display("[TB] FAIL sh_strb got=%b want=1100", ss); end
        total++; if (swd !== 32'hABCD_ABCD) begin bad++; $display("[TB] FAIL sh_wdata got=%h want=abcdabcd", swd); end
        total++; if (swr !== 1'b1) begin bad++; $display("[TB] FAIL sh_wr got=%b want=1", swr); end
        total++; if (sa !== 32'h2000) begin bad++; $display("[TB] FAIL sh_addr got=%h want=00002000", sa); end
        total++; if (rdb !== 32'h0) begin bad++; $display("[TB] FAIL sh_data_b got=%h want=00000000", rdb); end
        run_memop(OP_SB, 32'h3001, 32'h0000_00A5, 0, 32'h0, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (ss !== 4'b0010) begin bad++; $display("[TB] FAIL sb_strb got=%b want=0010", ss); end
        total++; if (swd !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL sb_wdata got=%h want=a5a5a5a5", swd); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        int starts0;
        starts0 = req_starts;
        bus.ack = 1'b1;
        drive(OP_ADD, 32'h0, 32'h0, 32'h0000_0007, 5'd3);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL ack_in_idle_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        bus.ack = 1'b0;
        seq[3] = valid_out;
        total++; if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL ack_in_idle_req got=%b want=0", bus.req); end
        drive(OP_SW, 32'h4000, 32'h1234_5678, 32'h0, 5'd0);
        @(posedge clk); #1;
        seq[2] = valid_out;
        bus.ack = 1'b1;
        @(posedge clk); #1;
        seq[1] = valid_out;
        bus.ack = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 32'h0000_0009, 5'd4);
        @(posedge clk); #1;
        seq[0] = valid_out;
        valid_in = 1'b0;
        total++; if (seq !== 4'b1011) begin bad++; $display("[TB] FAIL b2b_valid_seq got=%b want=1011", seq); end
        total++; if (rd_data_a_out !== 32'h9) begin bad++; $display("[TB] FAIL b2b_add_data got=%h want=00000009", rd_data_a_out); end
        @(negedge clk);
        total++; if (req_starts - starts0 !== 1) begin bad++; $display("[TB] FAIL b2b_req_count got=%0d want=1", req_starts - starts0); end
    endtask

    task automatic test_reset_mid_busy();
        drive(OP_LW, 32'h1000, 32'h0, 32'h0, 5'd6);
        @(posedge clk); #1;
        total++; if (bus.req !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy_req_pre got=%b want=1", bus.req); end
        @(posedge clk); #2;
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({valid_out, oper_out, rd_regf_out, rd_data_a_out, rd_data_b, pc_out,
             exc_misalign, badvaddr, bus.req, bus.wr, bus.addr, bus.wstrb, bus.wdata} !== '0) begin
            bad++;
            $display("[TB] FAIL rst_busy_outputs got req=%b addr=%h want all zero", bus.req, bus.addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 32'h0000_55AA, 5'd7);
        pc = 32'h0000_2000;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_add_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy_add_valid got=%b want=1", valid_out); end
        total++; if (rd_data_a_out !== 32'h55AA) begin bad++; $display("[TB] FAIL rst_busy_add_data got=%h want=000055aa", rd_data_a_out); end
        total++; if ({rd_regf_out, oper_out, pc_out} !== {5'd7, OP_ADD, 32'h2000}) begin
            bad++; $display("[TB] FAIL rst_busy_add_fields got=%0d %h %h want=7 01 00002000", rd_regf_out, oper_out, pc_out);
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        int starts0;
        starts0 = req_starts;
        drive(OP_LW, 32'h1001, 32'h0, 32'h0, 5'd9);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL mis_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        total++; if (bus.req !== 1'b0) begin bad++; $display("[TB] FAIL mis_req got=%b want=0", bus.req); end
        total++; if ({valid_out, exc_misalign} !== 2'b11) begin bad++; $display("[TB] FAIL mis_exc got=%b%b want=11", valid_out, exc_misalign); end
        total++; if (badvaddr !== 32'h1001) begin bad++; $display("[TB] FAIL mis_badvaddr got=%h want=00001001", badvaddr); end
        total++; if (rd_regf_out !== 5'd0) begin bad++; $display("[TB] FAIL mis_rd_regf got=%0d want=0", rd_regf_out); end
        @(posedge clk); #1;
        total++; if (exc_misalign !== 1'b0) begin bad++; $display("[TB] FAIL mis_exc_clear got=%b want=0", exc_misalign); end
        total++; if (req_starts !== starts0) begin bad++; $display("[TB] FAIL mis_req_count got=%0d want=%0d", req_starts, starts0); end
`else
        int sc; logic sreq, swr, rv, rreq; logic [31:0] sa, swd, rdb; logic [3:0] ss;
        run_memop(OP_LW, 32'h1001, 32'h0, 0, 32'hCAFE_F00D, sc, sreq, swr, sa, ss, swd, rv, rdb, rreq);
        total++; if (sa !== 32'h1000) begin bad++; $display("[TB] FAIL forced_align_addr got=%h want=00001000", sa); end
        total++; if (rdb !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL forced_align_data got=%h want=cafef00d", rdb); end
        total++; if ({exc_misalign, badvaddr} !== 33'd0) begin bad++; $display("[TB] FAIL forced_align_exc got=%b %h want=0 00000000", exc_misalign, badvaddr); end
`endif
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_load_ext();
        test_store();
        test_back_to_back();
        test_reset_mid_busy();
        test_misalign();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage of the MIPS datapath, between EX and WB. It decodes the load/store class of the current `oper` and runs a single-outstanding request/acknowledge transaction on the data bus. It stalls the pipeline until the bus acknowledges, then aligns and sign- or zero-extends the load data. The result is registered as `rd_data_b` for the writeback source mux, alongside the passthrough ALU result `rd_data_a`, `pc`, `oper` and destination register.

## Interface
- No parameters; widths come from `` `W_OPER``/`` `W_REGF``/`` `W_DATA``/`` `W_ADDR``.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: EX/MEM slot holds a live instruction.
- `oper` in `` `W_OPER``: operation code.
- `addr` in `` `W_ADDR``: effective address (ALU result).
- `wr_data` in `` `W_DATA``: store data (rt).
- `rd_data_a` in `` `W_DATA``: ALU result passthrough.
- `pc` in `` `W_ADDR``: link value passthrough.
- `rd_regf` in `` `W_REGF``: destination register.
- `stall` out 1: combinational; upstream holds all inputs while high.
- `bus_req`, `bus_wr` out 1; `bus_addr` out 32; `bus_wstrb` out 4; `bus_wdata` out 32: registered bus request.
- `bus_ack` in 1; `bus_rdata` in 32: acknowledge, with read data valid in the same cycle.
- `valid_out`, `oper_out`, `rd_regf_out`, `rd_data_a_out`, `rd_data_b`, `pc_out` out: registered MEM/WB outputs.
- `exc_misalign` out 1; `badvaddr` out 32: registered; active only with the macro below.

## Operation
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Little-endian. Lane = `addr[1:0]`.
- FSM has two states:
  - IDLE: if `valid_in` and memop (and aligned), `stall`=1. At the edge it loads the bus registers, sets `bus_req`=1 and moves to BUSY.
  - BUSY: `stall` = !`bus_ack`. On `bus_ack` it drops `bus_req` at the edge and returns to IDLE.
- Bus fields:
  - `bus_addr` = {`addr`[31:2],2'b00}.
  - Loads: `bus_wr`=0, `bus_wstrb`=0000.
  - SB: strobe 0001<<lane, data byte replicated ×4.
  - SH: strobe 0011<<(`addr[1]`·2), data half replicated ×2.
  - SW: strobe 1111.
- Load extension:
  - LB/LBU: byte selected by lane, extended to 32 bits; sign-extended for LB, zero-extended for LBU.
  - LH/LHU: half selected by `addr[1]`, extended to 32 bits; sign-extended for LH, zero-extended for LHU.
  - LW: `bus_rdata` unchanged.
  - Stores: `rd_data_b`=0.
- Output register updates on every edge:
  - `stall`=0: capture `valid_in`/`oper`/`rd_regf`/`rd_data_a`/`pc`. Capture extended `bus_rdata` if a load was acknowledged this cycle, else 0.
  - `stall`=1: `valid_out`←0 (bubble); other fields don't care.
- Non-memop or `valid_in`=0: no bus activity, `stall`=0, passthrough.
- A new instruction is never accepted in the ack cycle's IDLE transition. The next memop starts from IDLE on the following cycle.

## Timing
- Reset: state IDLE; every output 0; `bus_req` drops asynchronously.
- Non-memop latency: 1 cycle.
- Memop latency: 2+W cycles to `valid_out`, where W is the number of BUSY cycles before `bus_ack`. Minimum 2 (ack in the first BUSY cycle).
- `bus_ack` in IDLE: ignored.
- `bus_req` is held with stable fields until ack.
- Reset mid-BUSY: transaction abandoned, no output produced.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are LH/LHU/SH with `addr[0]`, or LW/SW with `addr[1:0]`≠0.
  - A misaligned access issues no bus request and sets `stall`=0.
  - Next cycle: `valid_out`=1, `exc_misalign`=1, `badvaddr`=`addr`, `rd_regf_out`=0 (write suppressed).
  - `exc_misalign` lasts one cycle unless the next instruction is also misaligned.
- Undefined: `exc_misalign`/`badvaddr` tied 0. The offending low address bits are ignored (forced alignment).

## Structure
- Shared package `mem_pkg`:
  - `mm_kind_t` enum (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW).
  - `decode_mm(oper)` function.
  - FSM state typedef.
- One sub-module `load_ext`: combinational lane select and extension.

## Test plan
- Reset mid-BUSY, LW in flight: `bus_req`=0 immediately, all outputs 0, FSM in IDLE; a following ADD passes through normally.
- LW at 0x1000, ack after 3 BUSY cycles, `bus_rdata`=0xDEADBEEF: `stall` high 4 cycles; `rd_data_b`=0xDEADBEEF with `valid_out`=1 on the 5th cycle.
- LB at 0x1003, `bus_rdata`=0x80FF_0000: `rd_data_b`=0xFFFFFF80. LBU at the same address: 0x00000080. LH at 0x1002: 0xFFFF80FF.
- SH at 0x2002, `wr_data`=0x0000ABCD: `bus_wstrb`=1100, `bus_wdata`=0xABCDABCD, `bus_wr`=1, `rd_data_b`=0.
- Back-to-back ADD, SW (ack immediate), ADD: `valid_out` sequence 1,0,1,1; exactly one bus request is issued.
- With `MEM_ALIGN_CHECK_EN`: LW at 0x1001 gives no `bus_req`, `exc_misalign`=1, `badvaddr`=0x1001, `rd_regf_out`=0. Without the macro, the same LW reads 0x1000.
